// File: rtl/seq_control_unit.sv
// Multi-cycle sequencing control unit: owns the T-state machine, latches the fetched
// instruction and drives register-file, memory and PC strobes for reg/direct/indirect modes.
module seq_control_unit #(
  parameter int ADDR_W   = 8,
  parameter int REG_W    = 6,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] dataout_mem,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addsel,
  output logic [REG_W-1:0]  loadsel,
  output logic              rsel,
  output logic              selpc,
  output logic              pcadd_en,
  output logic              ir_load,
  output logic              exec_en,
  output logic [4:0]        t_state,
  output logic              halted,
  output logic              illegal,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPER   = 3'd2,
    S_INDIR  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [REG_W-1:0] NOREG     = '1;
  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t            state, state_nx;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        wait_cnt, wait_cnt_nx;
  logic              illegal_nx, bus_err_nx;
  logic              ir_we, ptr_we, mem_state;

  logic [1:0]        mode;
  logic [5:0]        op;
  logic [REG_W-1:0]  dest;
  logic [ADDR_W-1:0] src1, src2;
  logic              is_alu, is_mov, is_load, is_store, is_jump, is_halt, op_legal;
  logic              unused_ir;

  assign mode      = ir[31:30];
  assign op        = ir[29:24];
  assign dest      = ir[16 +: REG_W];
  assign src2      = ir[8 +: ADDR_W];
  assign src1      = ir[0 +: ADDR_W];
  assign unused_ir = ^ir;

  always_comb begin
    is_alu   = 1'b0;
    is_mov   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_jump  = 1'b0;
    is_halt  = 1'b0;
    case (op)
      6'h00, 6'h01, 6'h20, 6'h21, 6'h22,
      6'h08, 6'h09, 6'h0a, 6'h0b: is_alu   = 1'b1;
      6'h10, 6'h11, 6'h12:        is_mov   = 1'b1;
      6'h15:                      is_load  = 1'b1;
      6'h2a:                      is_store = 1'b1;
      6'h33:                      is_jump  = 1'b1;
      6'h3f:                      is_halt  = 1'b1;
      default: ;
    endcase
    op_legal = is_alu | is_mov | is_load | is_store | is_jump | is_halt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ir       <= '0;
      ptr      <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      illegal  <= illegal_nx;
      bus_err  <= bus_err_nx;
      if (ir_we)  ir  <= instr;
      if (ptr_we) ptr <= dataout_mem;
    end
  end

  // Memory handshake: the unit holds its request (read/write/addsel) for as long as it
  // sits in a memory state; a cycle with mem_ready high completes the access and the
  // state advances on that edge. mem_ready in any other state is ignored.
  always_comb begin
    state_nx    = state;
    illegal_nx  = illegal;
    bus_err_nx  = bus_err;
    ir_we       = 1'b0;
    ptr_we      = 1'b0;
    wait_cnt_nx = '0;
    mem_state   = (state == S_FETCH) || (state == S_OPER) || (state == S_INDIR);
    case (state)
      S_FETCH: if (mem_ready) begin
        ir_we    = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (mode == 2'd3 || !op_legal) begin
          illegal_nx = 1'b1;
          state_nx   = S_HALT;
        end else if (is_halt) begin
          state_nx = S_HALT;
        end else if (mode == 2'd0 && (is_mov || is_jump)) begin
          state_nx = S_EXEC;
        end else begin
          state_nx = S_OPER;
        end
      end
      S_OPER: if (mem_ready) begin
        if (mode == 2'd2 && is_alu) begin
          ptr_we   = 1'b1;
          state_nx = S_INDIR;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_INDIR: if (mem_ready) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_FETCH;
      default: state_nx = S_HALT;
    endcase
    // A ready cycle always completes the access, so the timeout only fires on a stall.
    if (mem_state && !mem_ready) begin
      if (wait_cnt == WAIT_LAST) begin
        bus_err_nx = 1'b1;
        state_nx   = S_HALT;
      end else begin
        wait_cnt_nx = wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    addsel  = '0;
    loadsel = NOREG;
    rsel    = 1'b0;
    selpc   = 1'b0;
    exec_en = 1'b0;
    t_state = 5'b00000;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          read    = 1'b1;
          t_state = 5'b00001;
        end
        S_DECODE: t_state = 5'b00010;
        S_OPER: begin
          t_state = 5'b00100;
          if (is_alu || is_load) begin
            read   = 1'b1;
            addsel = src1;
          end else if (is_store) begin
            write  = 1'b1;
            addsel = src2;
          end
          rsel = (mode == 2'd2) && !is_mov && !is_load;
        end
        S_INDIR: begin
          t_state = 5'b01000;
          read    = 1'b1;
          addsel  = ptr;
        end
        S_EXEC: begin
          t_state = 5'b10000;
          exec_en = 1'b1;
          selpc   = is_jump;
          loadsel = (is_store || is_jump) ? NOREG : dest;
        end
        default: ;
      endcase
    end
  end

  assign ir_load  = rst_n && (state == S_FETCH) && mem_ready;
  assign pcadd_en = ir_load;
  assign halted   = rst_n && (state == S_HALT);

endmodule
